// File: rtl/conf_int_add_operand_stage.sv
// conf_int_add_operand_stage
//
// Registered operand-staging stage that feeds the a/b inputs of the
// combinational approximate integer adder. Each accepted operand pair is
// approximated (LSB truncation or round-to-nearest with saturation), then
// buffered in a small FIFO. The pair is presented on registered a/b outputs.
// The adder therefore sees neither upstream timing nor stall behaviour.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   in_valid     upstream operand pair valid
//   in_ready     stage can accept a pair this cycle (registers and rst only)
//   in_a, in_b   unsigned operands
//   cfg_apx_lsbs requested number of approximated LSBs (sampled per accept)
//   cfg_round    0 = truncate, 1 = round-to-nearest with saturation
//   a, b         staged operands to the adder
//   out_valid    a/b hold a valid pair
//   out_ready    downstream consumes a/b this cycle
//   occupancy    pairs held (FIFO plus output register)
module conf_int_add_operand_stage #(
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int OP_BITWIDTH        = 16,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0]       in_a,
  input  logic [DATA_PATH_BITWIDTH-1:0]       in_b,
  input  logic [$clog2(DATA_PATH_BITWIDTH):0] cfg_apx_lsbs,
  input  logic                                cfg_round,
  output logic [DATA_PATH_BITWIDTH-1:0]       a,
  output logic [DATA_PATH_BITWIDTH-1:0]       b,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(FIFO_DEPTH+2)-1:0]     occupancy
);

  localparam int DW = DATA_PATH_BITWIDTH;
  localparam int KW = $clog2(DATA_PATH_BITWIDTH) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(FIFO_DEPTH + 2);

  // The precision floor (DW - OP_BITWIDTH) always applies. Requests beyond
  // the datapath width clamp to a full-width approximation.
  function automatic logic [KW-1:0] eff_k(input logic [KW-1:0] req);
    logic [KW-1:0] base;
    logic [KW-1:0] k;
    base = KW'(DW - OP_BITWIDTH);
    k    = (req > base) ? req : base;
    if (k > KW'(DW)) k = KW'(DW);
    return k;
  endfunction

  // The mask and the rounding sum are built one bit wider than the datapath.
  // This keeps k = DW well defined, giving a zero mask. The extra bit also
  // exposes the rounding carry-out, which selects saturation.
  function automatic logic [DW-1:0] apx(input logic [DW-1:0] v,
                                        input logic [KW-1:0] k,
                                        input logic          rnd);
    logic [DW:0] mask;
    logic [DW:0] half;
    logic [DW:0] sum;
    mask = {(DW+1){1'b1}} << k;
    half = (k == '0) ? '0 : ({{DW{1'b0}}, 1'b1} << (k - KW'(1)));
    sum  = {1'b0, v} + half;
    if (!rnd)
      return v & mask[DW-1:0];
    else if (sum[DW])
      return mask[DW-1:0];
    else
      return sum[DW-1:0] & mask[DW-1:0];
  endfunction

  logic [KW-1:0]     k_p0;
  logic [DW-1:0]     apx_a_p0;
  logic [DW-1:0]     apx_b_p0;
  logic              accept_p0;
  logic              load_p1;
  logic              fifo_empty;
  logic              fifo_rd;
  logic              fifo_wr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic [2*DW-1:0]   mem [FIFO_DEPTH];

  // ---- p0: accept and approximate at the input ----
  assign accept_p0 = in_valid & in_ready;
  assign k_p0      = eff_k(cfg_apx_lsbs);
  assign apx_a_p0  = apx(in_a, k_p0, cfg_round);
  assign apx_b_p0  = apx(in_b, k_p0, cfg_round);

  // ---- p1: FIFO and output register ----
  // The output register reloads when empty or popped. The FIFO head always
  // has priority, which keeps strict order. An accepted pair bypasses the
  // FIFO only when the FIFO is empty and the register is free.
  assign load_p1    = ~out_valid | out_ready;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_rd    = load_p1 & ~fifo_empty;
  assign fifo_wr    = accept_p0 & ~(load_p1 & fifo_empty);

  assign occupancy = OW'(fifo_cnt) + OW'(out_valid);
  // The full test uses registered occupancy only, so a same-cycle pop
  // never opens the input.
  assign in_ready  = rst & (occupancy < OW'(FIFO_DEPTH + 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      a         <= '0;
      b         <= '0;
      out_valid <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(fifo_wr) - CW'(fifo_rd);
      if (load_p1) begin
        if (!fifo_empty) begin
          {a, b}    <= mem[rd_ptr];
          out_valid <= 1'b1;
        end else if (accept_p0) begin
          a         <= apx_a_p0;
          b         <= apx_b_p0;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= {apx_a_p0, apx_b_p0};
  end

endmodule

// File: tb/tb_conf_int_add_operand_stage.sv
module tb_conf_int_add_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [4:0]  cfg_apx_lsbs;
  logic        cfg_round;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  occupancy;

  int checks = 0;
  int errors = 0;
  logic [31:0] expq[$];

  always #5 clk = ~clk;

  conf_int_add_operand_stage #(
    .DATA_PATH_BITWIDTH(16),
    .OP_BITWIDTH(12),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .cfg_apx_lsbs(cfg_apx_lsbs), .cfg_round(cfg_round),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  // Reference model in plain integer arithmetic. The value is quantised to a
  // multiple of 2^k. In the rounding case, overflow gives the largest
  // multiple of 2^k that fits in 16 bits.
  function automatic logic [15:0] ref_apx(input int v, input int cfg, input bit rnd);
    int k;
    int p;
    int r;
    k = (cfg > 4) ? cfg : 4;
    if (k > 16) k = 16;
    p = 1 << k;
    if (!rnd) r = (v / p) * p;
    else begin
      r = ((v + p / 2) / p) * p;
      if (r > 65535) r = 65536 - p;
    end
    return r[15:0];
  endfunction

  // Scoreboard and monitor. The model's view of what the stage holds is
  // the number of pairs in the queue.
  bit          stall_prev = 0;
  logic [15:0] pa, pb;
  always @(negedge clk) begin
    if (!rst) begin
      expq.delete();
      stall_prev = 0;
    end else begin
      chk("occupancy", 32'(occupancy), 32'(expq.size()));
      chk("in_ready", 32'(in_ready), 32'(expq.size() < 5));
      chk("out_valid", 32'(out_valid), 32'(expq.size() > 0));
      if (stall_prev && out_valid) chk("stall_hold", {a, b}, {pa, pb});
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("pop_unexpected", 32'(1), 32'(0));
        else chk("pair_out", {a, b}, expq.pop_front());
      end
      if (in_valid && in_ready)
        expq.push_back({ref_apx(int'(in_a), int'(cfg_apx_lsbs), cfg_round),
                        ref_apx(int'(in_b), int'(cfg_apx_lsbs), cfg_round)});
      stall_prev = out_valid && !out_ready;
      pa = a;
      pb = b;
    end
  end

  // Hold a pair on the input until it is accepted. Returns 1 ns after the
  // accepting edge.
  task automatic send(input logic [15:0] va, input logic [15:0] vb);
    bit done = 0;
    int n = 0;
    in_valid = 1'b1;
    in_a = va;
    in_b = vb;
    while (!done && n < 50) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) chk("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    cfg_apx_lsbs = '0;
    cfg_round = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_a", 32'(a), 32'(0));
    chk("rst_b", 32'(b), 32'(0));
    chk("rst_occupancy", 32'(occupancy), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("in_ready_after_release", 32'(in_ready), 32'(1));

    // Directed approximation cases
    send(16'h1234, 16'h00FF);
    in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid), 32'(1));
    chk("t1_a", 32'(a), 32'h1230);
    chk("t1_b", 32'(b), 32'h00F0);
    chk("t1_occ", 32'(occupancy), 32'(1));
    cfg_round = 1'b1;
    send(16'h1238, 16'hFFF8);
    in_valid = 1'b0;
    chk("t2_a", 32'(a), 32'h1240);
    chk("t2_b", 32'(b), 32'hFFF0);
    cfg_round = 1'b0;
    cfg_apx_lsbs = 5'd8;
    send(16'hABCD, 16'h00FF);
    in_valid = 1'b0;
    chk("t3_a", 32'(a), 32'hAB00);
    chk("t3_b", 32'(b), 32'h0000);
    cfg_apx_lsbs = 5'd16;
    send(16'hFFFF, 16'h8000);
    in_valid = 1'b0;
    chk("t3_k16_a", {a, b}, 32'h0);
    cfg_round = 1'b1;
    send(16'hFFFF, 16'h8000);
    in_valid = 1'b0;
    chk("t3_k16_round", {a, b}, 32'h0);
    cfg_round = 1'b0;
    cfg_apx_lsbs = '0;
    idle(2);

    // Fill while stalled, then drain in order
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(16'(i << 4), 16'(i << 8));
    chk("t4_full_ready", 32'(in_ready), 32'(0));
    chk("t4_full_occ", 32'(occupancy), 32'(5));
    in_a = 16'h0060;
    in_b = 16'h0600;
    repeat (2) @(posedge clk);
    #1;
    chk("t4_stall_a", 32'(a), 32'h0010);
    chk("t4_still_full", 32'(in_ready), 32'(0));
    out_ready = 1'b1;
    send(16'h0060, 16'h0600);
    send(16'h0070, 16'h0700);
    idle(10);
    chk("t4_drained", 32'(expq.size()), 32'(0));

    // Back-to-back stream at full throughput
    for (int i = 0; i < 20; i++) begin
      cfg_apx_lsbs = 5'($urandom_range(0, 31));
      cfg_round = 1'($urandom);
      send(16'($urandom), 16'($urandom));
      chk("t5_occ", 32'(occupancy), 32'(1));
    end
    idle(3);

    // Randomised handshakes on both sides
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      cfg_apx_lsbs = 5'($urandom_range(0, 31));
      cfg_round = 1'($urandom);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(8);
    chk("rand_drained", 32'(expq.size()), 32'(0));

    // Reset mid-operation
    cfg_apx_lsbs = '0;
    cfg_round = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(16'(i << 8), 16'(i << 12));
    in_valid = 1'b0;
    chk("t6_occ3", 32'(occupancy), 32'(3));
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'(0));
    chk("t6_ab", {a, b}, 32'h0);
    chk("t6_occ", 32'(occupancy), 32'(0));
    chk("t6_in_ready", 32'(in_ready), 32'(0));
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    send(16'h5555, 16'h0AAF);
    in_valid = 1'b0;
    chk("t6_latency", 32'(out_valid), 32'(1));
    chk("t6_pair", {a, b}, 32'h55500AA0);
    idle(4);
    chk("t6_drained", 32'(expq.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conf_int_add_operand_stage.md
Name: conf_int_add_operand_stage

Overview:
Registered operand-staging stage directly upstream of the combinational no-flop approximate integer adder. Accepts operand pairs over a valid/ready handshake, applies the configured approximation (LSB truncation or round-to-nearest with saturation), buffers pairs in a small FIFO, and presents them on registered a/b outputs that drive the adder's a/b inputs. It isolates the adder from upstream timing and stall behaviour.

Parameters:
DATA_PATH_BITWIDTH, 16, width of operands and of the a/b outputs
OP_BITWIDTH, 16, operator precision; the low DATA_PATH_BITWIDTH-OP_BITWIDTH bits are always approximated (must be <= DATA_PATH_BITWIDTH)
FIFO_DEPTH, 4, number of FIFO entries (power of two, >= 2)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  upstream operand pair valid
in_ready  out  1  stage can accept a pair this cycle
in_a  in  DATA_PATH_BITWIDTH  operand A
in_b  in  DATA_PATH_BITWIDTH  operand B
cfg_apx_lsbs  in  $clog2(DATA_PATH_BITWIDTH)+1  requested number of approximated LSBs
cfg_round  in  1  0 = truncate, 1 = round-to-nearest with saturation
a  out  DATA_PATH_BITWIDTH  staged operand A to the adder
b  out  DATA_PATH_BITWIDTH  staged operand B to the adder
out_valid  out  1  a/b hold a valid pair
out_ready  in  1  downstream has consumed a/b this cycle
occupancy  out  $clog2(FIFO_DEPTH+2)  pairs held, FIFO plus output register

Behaviour:
- Reset (rst low, asynchronous): FIFO pointers, occupancy, a, b, and out_valid go to 0. in_ready is 0 while rst is low and 1 in the first cycle after release.
- Transfer rules: input accept = in_valid & in_ready. Output pop = out_valid & out_ready.
- in_ready = (occupancy < FIFO_DEPTH+1). It is driven only from registers, with no combinational path from out_ready. A push and a pop in the same cycle leave occupancy unchanged.
- Approximation is applied at accept, so stored values are already processed. cfg is sampled per pair at its accept edge.
  - k = max(DATA_PATH_BITWIDTH-OP_BITWIDTH, cfg_apx_lsbs), clamped to DATA_PATH_BITWIDTH.
  - k = 0: value passes unchanged.
  - Truncate: zero the low k bits.
  - Round: add 2^(k-1) in DATA_PATH_BITWIDTH+1 bits, then zero the low k bits. On carry-out, saturate to all-ones with the low k bits zeroed.
  - k = DATA_PATH_BITWIDTH: result is 0 in both modes.
  - Operands are unsigned.
- Output register loading: the register loads when it is empty or being popped.
  - Source is the FIFO head if the FIFO is non-empty.
  - Otherwise an accepted pair bypasses the FIFO straight into the register.
  - If the register cannot load, the accepted pair is written to the FIFO.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Strict FIFO order at all times.
- Stall: when out_valid is high and out_ready is low, a and b hold stable.
- Full: occupancy = FIFO_DEPTH+1 forces in_ready = 0. A pop in that cycle does not admit a same-cycle push; in_ready rises the following cycle.
- Empty: out_valid = 0 and a/b retain their last values. The adder output is don't-care in this state.
- Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation discards all held pairs.

Test Plan:
1. DATA_PATH_BITWIDTH=16, OP_BITWIDTH=12, cfg_apx_lsbs=0, cfg_round=0, push in_a=0x1234, in_b=0x00FF -> next cycle out_valid=1, a=0x1230, b=0x00F0, occupancy=1.
2. Same parameters, cfg_round=1, push in_a=0x1238, in_b=0xFFF8 -> a=0x1240, b=0xFFF0 (saturated).
3. cfg_apx_lsbs=8, truncate, push 0xABCD/0x00FF -> a=0xAB00, b=0x0000. cfg_apx_lsbs=16 -> a=b=0.
4. out_ready held 0, in_valid held 1 with pairs 1..7 -> pairs 1..5 accepted, in_ready=0 after the 5th accept, occupancy=5. Release out_ready -> pairs 1..7 emerge in order, one per cycle, with no duplicates.
5. out_ready=1 continuously with a back-to-back stream -> one pair per cycle throughput, 1-cycle latency, occupancy stays at 1.
6. Assert rst low mid-stream with occupancy=3 -> immediately out_valid=0, a=b=0, occupancy=0. After release, the first new pair appears 1 cycle after its accept.
